// File: rtl/irq_request_controller_pkg.sv
// Shared constants for the interrupt request controller: register map,
// FSM state encodings and CAUSE register layout.
package irq_pkg;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_CAUSE   = 2'd2;
  localparam logic [1:0] REG_EDGE    = 2'd3;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] REQUEST    = 2'd1;
  localparam logic [1:0] IN_SERVICE = 2'd2;
  localparam logic [1:0] COMPLETE   = 2'd3;

  localparam int CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/irq_request_controller_edge_detect.sv
// Per-source input conditioning: optional 2-flop synchronizer (IRQ_SYNC_EN),
// previous-value register and rising-edge pulse.
module irq_edge_detect (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_irq,
  output logic O_level,
  output logic O_rise
);

  logic prev_q;

`ifdef IRQ_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) sync_q <= '0;
    else       sync_q <= {sync_q[0], I_irq};
  end

  assign O_level = sync_q[1];
`else
  assign O_level = I_irq;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) prev_q <= 1'b0;
    else       prev_q <= O_level;
  end

  assign O_rise = O_level & ~prev_q;

endmodule

// File: rtl/irq_request_controller.sv
// Interrupt request controller: latches pending sources, masks, picks the
// lowest enabled index and hands it to the handler FSM. Optional macro: IRQ_SYNC_EN.
module irq_request_controller
  import irq_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int ID_BITS     = 2,
  parameter int DATA_BITS   = 32
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic [NUM_SOURCES-1:0] I_irq,
  input  logic                   I_wr_en,
  input  logic [1:0]             I_addr,
  input  logic [DATA_BITS-1:0]   I_wr_data,
  output logic [DATA_BITS-1:0]   O_rd_data,
  input  logic                   I_interrupt_happening,
  input  logic                   I_interrupt_done,
  output logic                   O_request,
  output logic [ID_BITS-1:0]     O_cause_id,
  output logic                   O_cause_valid
);

  logic [NUM_SOURCES-1:0] enable_q, edge_mode_q, pending_q, pending_d;
  logic [NUM_SOURCES-1:0] level, rise, w1c, svc_clr, eligible;
  logic [ID_BITS-1:0]     winner;
  logic [1:0]             state_q;
  logic                   unused_wr_data;

  assign unused_wr_data = ^I_wr_data[DATA_BITS-1:NUM_SOURCES];

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    irq_edge_detect u_edge (
      .I_clk   (I_clk),
      .I_rst   (I_rst),
      .I_irq   (I_irq[g]),
      .O_level (level[g]),
      .O_rise  (rise[g])
    );
  end

  assign w1c = (I_wr_en && I_addr == REG_PENDING) ? I_wr_data[NUM_SOURCES-1:0] : '0;

  // Served edge source is retired on every COMPLETE cycle; a fresh rise in the
  // same cycle still wins because the set term is ORed in last.
  assign svc_clr = (state_q == COMPLETE)
                 ? ((NUM_SOURCES'(1) << O_cause_id) & edge_mode_q) : '0;

  assign pending_d = (edge_mode_q & ((pending_q & ~w1c & ~svc_clr) | rise))
                   | (~edge_mode_q & level);

  assign eligible = pending_q & enable_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_BITS'(i);
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      enable_q    <= '0;
      edge_mode_q <= '0;
      pending_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (I_wr_en && I_addr == REG_ENABLE) enable_q    <= I_wr_data[NUM_SOURCES-1:0];
      if (I_wr_en && I_addr == REG_EDGE)   edge_mode_q <= I_wr_data[NUM_SOURCES-1:0];
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q       <= IDLE;
      O_request     <= 1'b0;
      O_cause_id    <= '0;
      O_cause_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eligible != '0) begin
            O_cause_id    <= winner;
            O_cause_valid <= 1'b1;
            O_request     <= 1'b1;
            state_q       <= REQUEST;
          end
        end
        // Cause stays frozen from here on; later arrivals never preempt.
        REQUEST: begin
          if (I_interrupt_happening) begin
            O_request <= 1'b0;
            state_q   <= IN_SERVICE;
          end
        end
        IN_SERVICE: begin
          if (I_interrupt_done) state_q <= COMPLETE;
        end
        COMPLETE: begin
          if (!I_interrupt_happening) begin
            O_cause_valid <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          O_request     <= 1'b0;
          O_cause_valid <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    O_rd_data = '0;
    case (I_addr)
      REG_ENABLE:  O_rd_data[NUM_SOURCES-1:0] = enable_q;
      REG_PENDING: O_rd_data[NUM_SOURCES-1:0] = pending_q;
      REG_CAUSE: begin
        O_rd_data[CAUSE_VALID_BIT] = O_cause_valid;
        O_rd_data[ID_BITS-1:0]     = O_cause_id;
      end
      default:     O_rd_data[NUM_SOURCES-1:0] = edge_mode_q;
    endcase
  end

endmodule

// File: tb/tb_irq_request_controller.sv
// Self-checking bench: expected cause IDs are queued when stimulus is driven and
// popped by a monitor each time O_request rises; register reads checked inline.
module tb_irq_request_controller;
  import irq_pkg::*;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic [3:0]  I_irq = '0;
  logic        I_wr_en = 1'b0;
  logic [1:0]  I_addr = '0;
  logic [31:0] I_wr_data = '0;
  logic [31:0] O_rd_data;
  logic        I_interrupt_happening = 1'b0;
  logic        I_interrupt_done = 1'b0;
  logic        O_request;
  logic [1:0]  O_cause_id;
  logic        O_cause_valid;

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  logic [1:0] exp_q[$];
  logic req_prev = 1'b0;

  irq_request_controller #(.NUM_SOURCES(4), .ID_BITS(2), .DATA_BITS(32)) dut (
    .I_clk                 (I_clk),
    .I_rst                 (I_rst),
    .I_irq                 (I_irq),
    .I_wr_en               (I_wr_en),
    .I_addr                (I_addr),
    .I_wr_data             (I_wr_data),
    .O_rd_data             (O_rd_data),
    .I_interrupt_happening (I_interrupt_happening),
    .I_interrupt_done      (I_interrupt_done),
    .O_request             (O_request),
    .O_cause_id            (O_cause_id),
    .O_cause_valid         (O_cause_valid)
  );

  always #5 I_clk = ~I_clk;

  // Scoreboard monitor: every new request must match the oldest queued cause.
  always @(negedge I_clk) begin
    if (I_rst) begin
      req_prev = 1'b0;
    end else begin
      if (O_request && !req_prev) begin
        req_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_request: got cause_id=%0d, required no request", O_cause_id);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          if (O_cause_id !== e || O_cause_valid !== 1'b1) begin
            errors++;
            $display("FAIL request_cause: got id=%0d valid=%0b, required id=%0d valid=1",
                     O_cause_id, O_cause_valid, e);
          end
        end
      end
      req_prev = O_request;
    end
  end

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(posedge I_clk); #1;
    I_wr_en = 1'b1; I_addr = a; I_wr_data = d;
    @(posedge I_clk); #1;
    I_wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    I_addr = a;
    @(negedge I_clk);
    d = O_rd_data;
  endtask

  // Handler model: wait for request, then happening -> done -> back to WAIT.
  task automatic handle();
    int n = 0;
    while (O_request !== 1'b1 && n < 20) begin
      @(negedge I_clk);
      n++;
    end
    checks++;
    if (O_request !== 1'b1) begin
      errors++;
      $display("FAIL handle_wait: O_request=%b after %0d cycles, required 1", O_request, n);
    end else begin
      @(posedge I_clk); #1 I_interrupt_happening = 1'b1;
      @(posedge I_clk); #1 I_interrupt_done = 1'b1;
      checks++;
      if (O_request !== 1'b0 || O_cause_valid !== 1'b1) begin
        errors++;
        $display("FAIL in_service: request=%b valid=%b, required 0/1", O_request, O_cause_valid);
      end
      @(posedge I_clk); #1 I_interrupt_done = 1'b0;
      @(posedge I_clk); #1 I_interrupt_happening = 1'b0;
      @(posedge I_clk); #1;
      checks++;
      if (O_cause_valid !== 1'b0) begin
        errors++;
        $display("FAIL after_service: valid=%b, required 0", O_cause_valid);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (O_request !== 1'b0 || O_cause_valid !== 1'b0 || O_cause_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b id=%0d, required 0/0/0",
               O_request, O_cause_valid, O_cause_id);
    end
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h, required 0", a, d);
      end
    end
  endtask

  task automatic test_edge_single();
    logic [31:0] d;
    write_reg(REG_ENABLE, 32'h2);
    write_reg(REG_EDGE, 32'h2);
    exp_q.push_back(2'd1);
    @(posedge I_clk); #1 I_irq[1] = 1'b1; I_addr = REG_PENDING;
    @(posedge I_clk); #1 I_irq[1] = 1'b0;
    @(negedge I_clk);
    checks++;
    if (O_rd_data !== 32'h2 || O_request !== 1'b0) begin
      errors++;
      $display("FAIL edge_pending: pending=%h req=%b, required 2/0", O_rd_data, O_request);
    end
    @(negedge I_clk);
    checks++;
    if (O_request !== 1'b1) begin
      errors++;
      $display("FAIL edge_latency: req=%b, required 1", O_request);
    end
    handle();
    read_reg(REG_PENDING, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL edge_cleared: pending=%h, required 0", d);
    end
    read_reg(REG_CAUSE, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL edge_cause_reg: cause=%h, required 00000001", d);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    int start;
    write_reg(REG_ENABLE, 32'hF);
    write_reg(REG_EDGE, 32'hF);
    start = req_count;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    @(posedge I_clk); #1 I_irq = 4'b1100;
    @(posedge I_clk); #1 I_irq = 4'b0000;
    handle();
    handle();
    repeat (5) @(negedge I_clk);
    checks++;
    if (req_count - start !== 2) begin
      errors++;
      $display("FAIL same_cycle_count: requests=%0d, required 2", req_count - start);
    end
    read_reg(REG_PENDING, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL same_cycle_pending: pending=%h, required 0", d);
    end
  endtask

  task automatic test_enable_gate();
    logic [31:0] d;
    write_reg(REG_ENABLE, 32'h0);
    @(posedge I_clk); #1 I_irq[0] = 1'b1;
    @(posedge I_clk); #1 I_irq[0] = 1'b0;
    repeat (4) @(negedge I_clk);
    read_reg(REG_PENDING, d);
    checks++;
    if (d !== 32'h1 || O_request !== 1'b0) begin
      errors++;
      $display("FAIL masked: pending=%h req=%b, required 1/0", d, O_request);
    end
    exp_q.push_back(2'd0);
    write_reg(REG_ENABLE, 32'h1);
    @(negedge I_clk);
    @(negedge I_clk);
    checks++;
    if (O_request !== 1'b1) begin
      errors++;
      $display("FAIL enable_latency: req=%b, required 1", O_request);
    end
    handle();
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    write_reg(REG_ENABLE, 32'h0);
    @(posedge I_clk); #1 I_irq[0] = 1'b1;
    @(posedge I_clk); #1 I_irq[0] = 1'b0;
    @(posedge I_clk); #1;
    I_wr_en = 1'b1; I_addr = REG_PENDING; I_wr_data = 32'h1; I_irq[0] = 1'b1;
    @(posedge I_clk); #1;
    I_wr_en = 1'b0; I_irq[0] = 1'b0;
    read_reg(REG_PENDING, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL set_beats_w1c: pending=%h, required 1", d);
    end
    write_reg(REG_PENDING, 32'h1);
    read_reg(REG_PENDING, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL w1c_clear: pending=%h, required 0", d);
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    write_reg(REG_EDGE, 32'h0);
    @(posedge I_clk); #1 I_irq[0] = 1'b1;
    write_reg(REG_PENDING, 32'h1);
    read_reg(REG_PENDING, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL level_w1c_ignored: pending=%h, required 1", d);
    end
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    write_reg(REG_ENABLE, 32'h1);
    handle();
    @(negedge I_clk);
    @(negedge I_clk);
    checks++;
    if (O_request !== 1'b1) begin
      errors++;
      $display("FAIL level_rerequest: req=%b, required 1", O_request);
    end
    I_irq[0] = 1'b0;
    handle();
    repeat (8) @(negedge I_clk);
    read_reg(REG_PENDING, d);
    checks++;
    if (d !== 32'h0 || O_request !== 1'b0) begin
      errors++;
      $display("FAIL level_idle: pending=%h req=%b, required 0/0", d, O_request);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int n = 0;
    exp_q.push_back(2'd0);
    @(posedge I_clk); #1 I_irq[0] = 1'b1;
    while (O_request !== 1'b1 && n < 20) begin
      @(negedge I_clk);
      n++;
    end
    checks++;
    if (O_request !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait: req=%b, required 1", O_request);
    end
    @(posedge I_clk); #1 I_interrupt_happening = 1'b1;
    @(posedge I_clk); #3 I_rst = 1'b1;
    #1;
    checks++;
    if (O_request !== 1'b0 || O_cause_valid !== 1'b0 || O_cause_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: req=%b valid=%b id=%0d, required 0/0/0",
               O_request, O_cause_valid, O_cause_id);
    end
    I_irq = '0;
    I_interrupt_happening = 1'b0;
    @(posedge I_clk); #1 I_rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL mid_reset_reg%0d: got %h, required 0", a, d);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge I_clk);
    #1 I_rst = 1'b0;
    test_reset();
    test_edge_single();
    test_same_cycle();
    test_enable_gate();
    test_w1c_race();
    test_level();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected requests never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_request_controller.md
Name: irq_request_controller

Overview:
- Upstream stage of the interrupt handler FSM: collects up to NUM_SOURCES peripheral interrupt lines (timer, GPIO, UART), latches pending events, applies enable mask and fixed priority.
- Drives the single request line consumed by the handler.
- Tracks the handler's happening/done signals so each event is served exactly once.
- Exposes a small memory-mapped register file so firmware can enable, inspect and clear sources.

Parameters:
- NUM_SOURCES, 4, number of interrupt inputs (1..16).
- ID_BITS, 2, width of cause ID; must satisfy 2**ID_BITS >= NUM_SOURCES.
- DATA_BITS, 32, register bus width.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  asynchronous, active-high reset.
- I_irq  in  NUM_SOURCES  raw interrupt lines, active-high.
- I_wr_en  in  1  register write strobe.
- I_addr  in  2  register select, shared by reads and writes.
- I_wr_data  in  DATA_BITS  write data.
- O_rd_data  out  DATA_BITS  combinational read data for I_addr.
- I_interrupt_happening  in  1  handler is out of its WAIT state.
- I_interrupt_done  in  1  handler is in its completion phase.
- O_request  out  1  request to handler.
- O_cause_id  out  ID_BITS  source currently being served.
- O_cause_valid  out  1  a source is latched as in service.

Behaviour:
- Reset: O_request=0, O_cause_id=0, O_cause_valid=0; ENABLE=0, PENDING=0, EDGE_MODE=0 (all level); FSM=IDLE; edge history=0.
- Register map by I_addr:
  - 0 ENABLE: read/write.
  - 1 PENDING: read; write-1-to-clear.
  - 2 CAUSE: read-only; bit31=O_cause_valid, low bits=O_cause_id.
  - 3 EDGE_MODE: read/write; 1=rising-edge, 0=level.
  - Only bits [NUM_SOURCES-1:0] are stored; other bits read 0.
- Pending update each cycle:
  - Edge source: set on (irq & ~irq_prev).
  - Level source: PENDING bit mirrors the current irq level; W1C has no effect.
  - Set beats W1C in the same cycle.
- Eligible = PENDING & ENABLE. Winner = lowest eligible index.
- FSM (registered, 4 states):
  - IDLE: if eligible != 0, latch winner into O_cause_id, set O_cause_valid=1 and O_request=1; go to REQUEST.
  - REQUEST: hold O_request=1 until I_interrupt_happening=1, then O_request=0 and go to IN_SERVICE. Cause is frozen; a higher-priority arrival does not preempt.
  - IN_SERVICE: wait for I_interrupt_done=1, then go to COMPLETE.
  - COMPLETE: clear PENDING[O_cause_id] if that source is edge mode. Hold until I_interrupt_happening=0 (handler back in WAIT), then O_cause_valid=0 and go to IDLE.
- Latency, sync disabled: I_irq rise sampled at edge N → PENDING set at edge N → O_request high after edge N+1.
- A new edge on the served source during IN_SERVICE sets PENDING again but is cleared in COMPLETE (lost). A new edge arriving in COMPLETE on the cycle of the clear wins and re-requests.
- Level source deasserted while in REQUEST: request still completes; firmware reads CAUSE and sees the stale source.
- Disabling a source mid-service does not abort the service.
- Writing ENABLE while in IDLE takes effect for the next cycle's arbitration.
- I_rst mid-operation returns everything to reset values immediately; the handler is reset by the same I_rst.
- Unused encodings of the FSM state go to IDLE.

Optional Feature:
- IRQ_SYNC_EN:
  - Defined: each I_irq bit passes through a 2-flop synchronizer before edge/level logic, adding 2 cycles of request latency.
  - Undefined: I_irq is treated as synchronous to I_clk with no added stages.

Decomposition:
- Package irq_pkg holds:
  - register address constants REG_ENABLE=0, REG_PENDING=1, REG_CAUSE=2, REG_EDGE=3;
  - FSM state encodings IDLE/REQUEST/IN_SERVICE/COMPLETE;
  - CAUSE valid-bit position constant 31.
- Sub-module irq_edge_detect, one instance per source, contains the optional synchronizer, irq_prev register and rise pulse output.
- Priority encoder stays inline.

Test Plan:
- ENABLE=4'b0010, EDGE_MODE=4'b0010; pulse I_irq[1] for 1 cycle → PENDING=2 next edge; O_request=1 one cycle later with O_cause_id=1; handler sequence completes → PENDING=0, O_cause_valid=0.
- ENABLE=4'hF, EDGE_MODE=4'hF; I_irq[3] and I_irq[2] rise on the same cycle → first service cause_id=2, second cause_id=3, two O_request assertions total.
- ENABLE=0; pulse I_irq[0] → PENDING[0]=1, O_request stays 0; then write ENABLE=1 → O_request=1 within 1 cycle after the write edge.
- Edge source pending; write PENDING=4'h1 on the same cycle as a new I_irq[0] rise → PENDING[0] remains 1.
- Level mode source 0 held high through COMPLETE → new request is issued immediately after return to IDLE; deassert → no further request.
- Assert I_rst during IN_SERVICE → O_request=0, O_cause_valid=0, all registers read 0 on the next read.
